// File: rtl/cache_ctrl_pkg.sv
// Shared types and address-split helpers for the cache sequencing controller.
// The optional statistics counters are enabled by defining CACHE_CTRL_STATS_EN.
package cache_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOOKUP     = 4'd1,
    MERGE      = 4'd2,
    FILL_REQ   = 4'd3,
    FILL_WAIT  = 4'd4,
    FILL_WRITE = 4'd5,
    WT_REQ     = 4'd6,
    WT_WAIT    = 4'd7,
    RESP       = 4'd8
  } ctrl_state_e;

  localparam int unsigned DEF_XLEN      = 32;
  localparam int unsigned DEF_LINE_SIZE = 64;

  function automatic int unsigned word_off_bits(input int unsigned xlen);
    return $clog2(xlen / 32'd8);
  endfunction

  function automatic int unsigned line_off_bits(input int unsigned line_size);
    return $clog2(line_size);
  endfunction

  localparam int unsigned WOFF  = word_off_bits(DEF_XLEN);
  localparam int unsigned OFF_W = line_off_bits(DEF_LINE_SIZE);

endpackage

// File: rtl/cache_controller_if.sv
// CPU, memory and cache-array signal bundle of the cache controller.
// master = controller side, slave = core / memory adapter / cache side.
interface cache_controller_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned LINE_SIZE = 64
);

  logic                   cpu_req_valid;
  logic                   cpu_req_ready;
  logic                   cpu_req_write;
  logic [XLEN-1:0]        cpu_req_addr;
  logic [XLEN-1:0]        cpu_req_wdata;
  logic [XLEN/8-1:0]      cpu_req_wstrb;
  logic                   cpu_resp_valid;
  logic [XLEN-1:0]        cpu_resp_rdata;

  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_write;
  logic [XLEN-1:0]        mem_req_addr;
  logic [XLEN-1:0]        mem_req_wdata;
  logic [XLEN/8-1:0]      mem_req_wstrb;
  logic                   mem_resp_valid;
  logic [8*LINE_SIZE-1:0] mem_resp_line;

  logic [XLEN-1:0]        cache_address;
  logic                   cache_mem_write_en;
  logic                   cache_cpu_write_en;
  logic [8*LINE_SIZE-1:0] cache_data_in;
  logic [8*LINE_SIZE-1:0] cache_data_out;
  logic                   cache_hit;

  modport master (
    input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_line,
    output cache_address, cache_mem_write_en, cache_cpu_write_en, cache_data_in,
    input  cache_data_out, cache_hit
  );

  modport slave (
    output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_line,
    input  cache_address, cache_mem_write_en, cache_cpu_write_en, cache_data_in,
    output cache_data_out, cache_hit
  );

endinterface

// File: rtl/cache_controller_line_word_merge.sv
// Combinational word select and byte-strobe merge on one cache line.
// Shared by the hit lookup, the store merge and the refill response path.
module line_word_merge
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned LINE_SIZE = 64
) (
  input  logic [8*LINE_SIZE-1:0]                                          line_in,
  input  logic [line_off_bits(LINE_SIZE)-word_off_bits(XLEN)-1:0]         word_idx,
  input  logic [XLEN-1:0]                                                 wdata,
  input  logic [XLEN/8-1:0]                                               wstrb,
  output logic [XLEN-1:0]                                                 word_out,
  output logic [8*LINE_SIZE-1:0]                                          merged_line
);

  // Select the addressed word and overlay the enabled store bytes on it.
  always_comb begin
    word_out    = line_in[int'(word_idx)*XLEN +: XLEN];
    merged_line = line_in;
    for (int b = 0; b < int'(XLEN/8); b++) begin
      if (wstrb[b]) begin
        merged_line[int'(word_idx)*XLEN + b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
        merged_line[int'(word_idx)*XLEN + b*8 +: 8] = line_in[int'(word_idx)*XLEN + b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Write-through / no-write-allocate sequencing FSM in front of the line cache.
// Define CACHE_CTRL_STATS_EN to add saturating hit/miss/store counters.
module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned LINE_SIZE = 64
) (
  input  logic               clock,
  input  logic               reset,
  cache_controller_if.master bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses,
  output logic [31:0]        stat_writes
`endif
);

  localparam int unsigned WOFF_B = word_off_bits(XLEN);
  localparam int unsigned OFF_B  = line_off_bits(LINE_SIZE);
  localparam int unsigned LINE_W = 8 * LINE_SIZE;
  localparam int unsigned STRB_W = XLEN / 8;
  localparam logic [XLEN-1:0] LINE_MASK = {XLEN{1'b1}} << OFF_B;
  localparam logic [XLEN-1:0] WORD_MASK = {XLEN{1'b1}} << WOFF_B;

  ctrl_state_e         state_r, next_state_s;
  logic [XLEN-1:0]     req_addr_r, req_wdata_r, rdata_r, mem_addr_r, mem_addr_s;
  logic                req_write_r;
  logic [STRB_W-1:0]   req_wstrb_r;
  logic [LINE_W-1:0]   line_buf_r, line_sel_s, merged_line_s;
  logic [XLEN-1:0]     word_s;
  logic                accept_s;
  logic                ready_r, resp_valid_r, mem_valid_r, mem_write_r, fill_we_r, merge_we_r;
  logic                ready_s, resp_valid_s, mem_valid_s, mem_write_s, fill_we_s, merge_we_s;

  // ready_r is high only while in IDLE, so it doubles as the accept qualifier
  assign accept_s   = bus.cpu_req_valid && ready_r;
  assign line_sel_s = (state_r == FILL_WRITE) ? line_buf_r : bus.cache_data_out;

  line_word_merge #(.XLEN(XLEN), .LINE_SIZE(LINE_SIZE)) u_merge (
    .line_in     (line_sel_s),
    .word_idx    (req_addr_r[OFF_B-1:WOFF_B]),
    .wdata       (req_wdata_r),
    .wstrb       (req_wstrb_r),
    .word_out    (word_s),
    .merged_line (merged_line_s)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:       if (accept_s) next_state_s = LOOKUP; else next_state_s = IDLE;
      LOOKUP: begin
        case ({req_write_r, bus.cache_hit})
          2'b00:   next_state_s = FILL_REQ;
          2'b01:   next_state_s = RESP;
          2'b10:   next_state_s = WT_REQ;
          2'b11:   next_state_s = MERGE;
          default: next_state_s = IDLE;
        endcase
      end
      MERGE:      next_state_s = WT_REQ;
      FILL_REQ:   if (bus.mem_req_ready) next_state_s = FILL_WAIT; else next_state_s = FILL_REQ;
      FILL_WAIT:  if (bus.mem_resp_valid) next_state_s = FILL_WRITE; else next_state_s = FILL_WAIT;
      FILL_WRITE: next_state_s = RESP;
      WT_REQ:     if (bus.mem_req_ready) next_state_s = WT_WAIT; else next_state_s = WT_REQ;
      WT_WAIT:    if (bus.mem_resp_valid) next_state_s = RESP; else next_state_s = WT_WAIT;
      RESP:       next_state_s = IDLE;
      default:    next_state_s = IDLE;
    endcase
  end

  // Output decode on the next state so the registered strobes line up with the state.
  always_comb begin
    ready_s      = 1'b0;
    resp_valid_s = 1'b0;
    mem_valid_s  = 1'b0;
    mem_write_s  = 1'b0;
    fill_we_s    = 1'b0;
    merge_we_s   = 1'b0;
    mem_addr_s   = mem_addr_r;
    case (next_state_s)
      IDLE:       ready_s = 1'b1;
      MERGE:      merge_we_s = 1'b1;
      FILL_REQ: begin
        mem_valid_s = 1'b1;
        mem_addr_s  = req_addr_r & LINE_MASK;
      end
      FILL_WRITE: fill_we_s = 1'b1;
      WT_REQ: begin
        mem_valid_s = 1'b1;
        mem_write_s = 1'b1;
        mem_addr_s  = req_addr_r & WORD_MASK;
      end
      RESP:       resp_valid_s = 1'b1;
      default:    ready_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      mem_valid_r  <= 1'b0;
      mem_write_r  <= 1'b0;
      fill_we_r    <= 1'b0;
      merge_we_r   <= 1'b0;
      mem_addr_r   <= {XLEN{1'b0}};
    end else begin
      ready_r      <= ready_s;
      resp_valid_r <= resp_valid_s;
      mem_valid_r  <= mem_valid_s;
      mem_write_r  <= mem_write_s;
      fill_we_r    <= fill_we_s;
      merge_we_r   <= merge_we_s;
      mem_addr_r   <= mem_addr_s;
    end
  end

  // Request latch, line buffer and response data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_addr_r  <= {XLEN{1'b0}};
      req_write_r <= 1'b0;
      req_wdata_r <= {XLEN{1'b0}};
      req_wstrb_r <= {STRB_W{1'b0}};
      line_buf_r  <= {LINE_W{1'b0}};
      rdata_r     <= {XLEN{1'b0}};
    end else begin
      if (accept_s) begin
        req_addr_r  <= bus.cpu_req_addr;
        req_write_r <= bus.cpu_req_write;
        req_wdata_r <= bus.cpu_req_wdata;
        req_wstrb_r <= bus.cpu_req_wstrb;
      end
      case (state_r)
        LOOKUP: begin
          if (bus.cache_hit && req_write_r)  line_buf_r <= merged_line_s;
          if (bus.cache_hit && !req_write_r) rdata_r    <= word_s;
        end
        FILL_WAIT:  if (bus.mem_resp_valid) line_buf_r <= bus.mem_resp_line;
        FILL_WRITE: rdata_r <= word_s;
        WT_WAIT:    if (bus.mem_resp_valid) rdata_r <= {XLEN{1'b0}};
        default:    rdata_r <= rdata_r;
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  // Saturating lookup statistics, sampled at the LOOKUP closing edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
      stat_writes <= 32'd0;
    end else if (state_r == LOOKUP) begin
      if (bus.cache_hit && (stat_hits != 32'hFFFF_FFFF))    stat_hits   <= stat_hits + 32'd1;
      if (!bus.cache_hit && (stat_misses != 32'hFFFF_FFFF)) stat_misses <= stat_misses + 32'd1;
      if (req_write_r && (stat_writes != 32'hFFFF_FFFF))    stat_writes <= stat_writes + 32'd1;
    end
  end
`endif

  assign bus.cpu_req_ready      = ready_r;
  assign bus.cpu_resp_valid     = resp_valid_r;
  assign bus.cpu_resp_rdata     = rdata_r;
  assign bus.mem_req_valid      = mem_valid_r;
  assign bus.mem_req_write      = mem_write_r;
  assign bus.mem_req_addr       = mem_addr_r;
  assign bus.mem_req_wdata      = req_wdata_r;
  assign bus.mem_req_wstrb      = req_wstrb_r;
  assign bus.cache_address      = req_addr_r;
  assign bus.cache_mem_write_en = fill_we_r;
  assign bus.cache_cpu_write_en = merge_we_r;
  assign bus.cache_data_in      = line_buf_r;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a one-line cache model and a simple memory responder.
module tb_cache_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cache_controller_if #(.XLEN(32), .LINE_SIZE(64)) bus ();
  cache_controller #(.XLEN(32), .LINE_SIZE(64)) dut (.clock(clock), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic mem_ready_en = 1'b0;
  logic mem_resp_en  = 1'b1;
  logic force_resp   = 1'b0;
  logic resp_pend    = 1'b0;
  int   mem_acc_cnt = 0, fill_cnt = 0, merge_cnt = 0, both_cnt = 0;
  logic [31:0]  last_addr = 32'd0, last_wdata = 32'd0;
  logic         last_write = 1'b0;
  logic [3:0]   last_wstrb = 4'd0;
  logic         m_valid = 1'b0;
  logic [31:0]  m_tag = 32'd0;
  logic [511:0] m_line = 512'd0;

  function automatic logic [511:0] pattern();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = 32'hA000_0000 + k;
    return l;
  endfunction

  assign bus.mem_req_ready  = mem_ready_en;
  assign bus.mem_resp_valid = resp_pend | force_resp;
  assign bus.mem_resp_line  = pattern();
  assign bus.cache_hit      = m_valid && (m_tag == {bus.cache_address[31:6], 6'b0});
  assign bus.cache_data_out = m_line;

  // Memory responder, cache array model and strobe monitors.
  always @(posedge clock) begin
    cyc       <= cyc + 1;
    resp_pend <= 1'b0;
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      mem_acc_cnt <= mem_acc_cnt + 1;
      last_addr   <= bus.mem_req_addr;
      last_write  <= bus.mem_req_write;
      last_wdata  <= bus.mem_req_wdata;
      last_wstrb  <= bus.mem_req_wstrb;
      resp_pend   <= mem_resp_en;
    end
    if (bus.cache_mem_write_en) begin
      fill_cnt <= fill_cnt + 1;
      m_valid  <= 1'b1;
      m_tag    <= {bus.cache_address[31:6], 6'b0};
      m_line   <= bus.cache_data_in;
    end else if (bus.cache_cpu_write_en) begin
      merge_cnt <= merge_cnt + 1;
      m_line    <= bus.cache_data_in;
    end
    if (bus.cache_mem_write_en && bus.cache_cpu_write_en) both_cnt <= both_cnt + 1;
  end

  task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output int acc, output bit ok);
    @(negedge clock);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_write = wr;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_wdata = wdata;
    bus.cpu_req_wstrb = strb;
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cpu_req_ready) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    bus.cpu_req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int rcyc, output logic [31:0] rdata, output bit ok);
    ok = 1'b0; rcyc = 0; rdata = 32'd0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cpu_resp_valid) begin
        ok = 1'b1; rcyc = cyc; rdata = bus.cpu_resp_rdata;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    vectors++; if (bus.cpu_req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", bus.cpu_req_ready); end
    vectors++; if ({bus.cpu_resp_valid, bus.mem_req_valid, bus.cache_mem_write_en, bus.cache_cpu_write_en} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_strobes got %b exp 0000", {bus.cpu_resp_valid, bus.mem_req_valid, bus.cache_mem_write_en, bus.cache_cpu_write_en}); end
    vectors++; if ({bus.cache_address, bus.mem_req_addr, bus.cpu_resp_rdata} !== 96'd0) begin
      miscompares++; $display("FAIL reset_buses got %h exp 0", {bus.cache_address, bus.mem_req_addr, bus.cpu_resp_rdata}); end
    reset = 1'b0;
    @(negedge clock);
    vectors++; if (bus.cpu_req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready got %b exp 1", bus.cpu_req_ready); end
  endtask

  task automatic test_read_miss();
    int acc, rcyc, m0, f0, c0; bit ok1, ok2; logic [31:0] rd;
    m0 = mem_acc_cnt; f0 = fill_cnt; c0 = merge_cnt;
    mem_ready_en = 1'b1; mem_resp_en = 1'b1;
    start_req(1'b0, 32'h0000_1044, 32'd0, 4'd0, acc, ok1);
    wait_resp(rcyc, rd, ok2);
    vectors++; if ({ok1, ok2} !== 2'b11) begin miscompares++; $display("FAIL rdmiss_handshake got %b exp 11", {ok1, ok2}); end
    vectors++; if (rd !== 32'hA000_0001) begin miscompares++; $display("FAIL rdmiss_rdata got %h exp a0000001", rd); end
    vectors++; if (rcyc - acc + 1 !== 6) begin miscompares++; $display("FAIL rdmiss_latency got %0d exp 6", rcyc - acc + 1); end
    vectors++; if (mem_acc_cnt - m0 !== 1) begin miscompares++; $display("FAIL rdmiss_memreqs got %0d exp 1", mem_acc_cnt - m0); end
    vectors++; if ({last_write, last_addr} !== {1'b0, 32'h0000_1040}) begin
      miscompares++; $display("FAIL rdmiss_memaddr got %b/%h exp 0/00001040", last_write, last_addr); end
    vectors++; if (fill_cnt - f0 !== 1) begin miscompares++; $display("FAIL rdmiss_fill_pulse got %0d exp 1", fill_cnt - f0); end
    vectors++; if (merge_cnt - c0 !== 0) begin miscompares++; $display("FAIL rdmiss_merge got %0d exp 0", merge_cnt - c0); end
    @(negedge clock);
    vectors++; if (bus.cpu_resp_valid !== 1'b0) begin miscompares++; $display("FAIL rdmiss_resp_pulse got %b exp 0", bus.cpu_resp_valid); end
  endtask

  task automatic test_read_hit();
    int acc, rcyc, m0; bit ok1, ok2; logic [31:0] rd;
    m0 = mem_acc_cnt;
    start_req(1'b0, 32'h0000_1048, 32'd0, 4'd0, acc, ok1);
    wait_resp(rcyc, rd, ok2);
    vectors++; if ({ok1, ok2} !== 2'b11) begin miscompares++; $display("FAIL rdhit_handshake got %b exp 11", {ok1, ok2}); end
    vectors++; if (rd !== 32'hA000_0002) begin miscompares++; $display("FAIL rdhit_rdata got %h exp a0000002", rd); end
    vectors++; if (rcyc - acc + 1 !== 3) begin miscompares++; $display("FAIL rdhit_latency got %0d exp 3", rcyc - acc + 1); end
    vectors++; if (mem_acc_cnt - m0 !== 0) begin miscompares++; $display("FAIL rdhit_memreqs got %0d exp 0", mem_acc_cnt - m0); end
  endtask

  task automatic test_store_hit();
    int acc, rcyc, m0, f0, c0; bit ok1, ok2; logic [31:0] rd;
    m0 = mem_acc_cnt; f0 = fill_cnt; c0 = merge_cnt;
    start_req(1'b1, 32'h0000_1044, 32'h1122_3344, 4'b0011, acc, ok1);
    wait_resp(rcyc, rd, ok2);
    vectors++; if ({ok1, ok2} !== 2'b11) begin miscompares++; $display("FAIL sthit_handshake got %b exp 11", {ok1, ok2}); end
    vectors++; if (merge_cnt - c0 !== 1) begin miscompares++; $display("FAIL sthit_merge_pulse got %0d exp 1", merge_cnt - c0); end
    vectors++; if (fill_cnt - f0 !== 0) begin miscompares++; $display("FAIL sthit_fill got %0d exp 0", fill_cnt - f0); end
    vectors++; if (m_line[63:0] !== 64'hA000_3344_A000_0000) begin miscompares++; $display("FAIL sthit_line got %h exp a0003344a0000000", m_line[63:0]); end
    vectors++; if (mem_acc_cnt - m0 !== 1) begin miscompares++; $display("FAIL sthit_memreqs got %0d exp 1", mem_acc_cnt - m0); end
    vectors++; if ({last_write, last_addr, last_wdata, last_wstrb} !== {1'b1, 32'h0000_1044, 32'h1122_3344, 4'b0011}) begin
      miscompares++; $display("FAIL sthit_memwrite got %b/%h/%h/%b exp 1/00001044/11223344/0011", last_write, last_addr, last_wdata, last_wstrb); end
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL sthit_rdata got %h exp 0", rd); end
    vectors++; if (rcyc - acc + 1 !== 6) begin miscompares++; $display("FAIL sthit_latency got %0d exp 6", rcyc - acc + 1); end
  endtask

  task automatic test_store_miss();
    int acc, rcyc, m0, f0, c0; bit ok1, ok2; logic [31:0] rd;
    m0 = mem_acc_cnt; f0 = fill_cnt; c0 = merge_cnt;
    start_req(1'b1, 32'h0000_8000, 32'hDEAD_BEEF, 4'b1111, acc, ok1);
    wait_resp(rcyc, rd, ok2);
    vectors++; if ({ok1, ok2} !== 2'b11) begin miscompares++; $display("FAIL stmiss_handshake got %b exp 11", {ok1, ok2}); end
    vectors++; if ((fill_cnt - f0) + (merge_cnt - c0) !== 0) begin
      miscompares++; $display("FAIL stmiss_cache_strobes got %0d exp 0", (fill_cnt - f0) + (merge_cnt - c0)); end
    vectors++; if (mem_acc_cnt - m0 !== 1) begin miscompares++; $display("FAIL stmiss_memreqs got %0d exp 1", mem_acc_cnt - m0); end
    vectors++; if ({last_write, last_addr, last_wdata} !== {1'b1, 32'h0000_8000, 32'hDEAD_BEEF}) begin
      miscompares++; $display("FAIL stmiss_memwrite got %b/%h/%h exp 1/00008000/deadbeef", last_write, last_addr, last_wdata); end
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL stmiss_rdata got %h exp 0", rd); end
    vectors++; if (rcyc - acc + 1 !== 5) begin miscompares++; $display("FAIL stmiss_latency got %0d exp 5", rcyc - acc + 1); end
  endtask

  task automatic test_ready_stall();
    int acc, rcyc, m0; bit ok1, ok2, seen; logic [31:0] rd;
    m0 = mem_acc_cnt;
    mem_ready_en = 1'b0;
    start_req(1'b0, 32'h0000_2000, 32'd0, 4'd0, acc, ok1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req_valid) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    vectors++; if ({ok1, seen} !== 2'b11) begin miscompares++; $display("FAIL stall_reach_fillreq got %b exp 11", {ok1, seen}); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if ({bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr, bus.cpu_req_ready} !== {1'b1, 1'b0, 32'h0000_2000, 1'b0}) begin
        miscompares++; $display("FAIL stall_hold cycle %0d got v=%b w=%b a=%h rdy=%b exp 1/0/00002000/0", i,
                                bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr, bus.cpu_req_ready); end
      @(negedge clock);
    end
    vectors++; if (mem_acc_cnt - m0 !== 0) begin miscompares++; $display("FAIL stall_no_accept got %0d exp 0", mem_acc_cnt - m0); end
    mem_ready_en = 1'b1;
    wait_resp(rcyc, rd, ok2);
    vectors++; if ({ok2, rd} !== {1'b1, 32'hA000_0000}) begin miscompares++; $display("FAIL stall_rdata got %b/%h exp 1/a0000000", ok2, rd); end
  endtask

  task automatic test_reset_mid();
    int acc, rcyc, m0, f0; bit ok1, ok2, seen; logic [31:0] rd;
    m0 = mem_acc_cnt;
    mem_resp_en = 1'b0;
    start_req(1'b0, 32'h0000_3004, 32'd0, 4'd0, acc, ok1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_acc_cnt != m0) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    vectors++; if ({ok1, seen} !== 2'b11) begin miscompares++; $display("FAIL rstmid_reach_fillwait got %b exp 11", {ok1, seen}); end
    reset = 1'b1;
    #1;
    vectors++; if ({bus.cpu_req_ready, bus.cpu_resp_valid, bus.mem_req_valid, bus.mem_req_write,
                    bus.cache_mem_write_en, bus.cache_cpu_write_en} !== 6'd0) begin
      miscompares++; $display("FAIL rstmid_strobes got %b exp 000000", {bus.cpu_req_ready, bus.cpu_resp_valid,
                              bus.mem_req_valid, bus.mem_req_write, bus.cache_mem_write_en, bus.cache_cpu_write_en}); end
    vectors++; if ({bus.cache_address, bus.mem_req_addr, bus.cpu_resp_rdata, bus.mem_req_wstrb} !== 100'd0) begin
      miscompares++; $display("FAIL rstmid_buses got %h/%h/%h exp 0", bus.cache_address, bus.mem_req_addr, bus.cpu_resp_rdata); end
    vectors++; if (bus.cache_data_in !== 512'd0) begin miscompares++; $display("FAIL rstmid_linebuf got nonzero exp 0"); end
    @(negedge clock);
    reset = 1'b0;
    mem_resp_en = 1'b1;
    f0 = fill_cnt;
    @(negedge clock);
    force_resp = 1'b1;
    @(negedge clock);
    force_resp = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.cpu_resp_valid || bus.mem_req_valid) seen = 1'b1;
      @(negedge clock);
    end
    vectors++; if ({seen, fill_cnt - f0} !== {1'b0, 32'd0}) begin
      miscompares++; $display("FAIL rstmid_stray_resp got activity=%b fills=%0d exp 0/0", seen, fill_cnt - f0); end
    vectors++; if (bus.cpu_req_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle_ready got %b exp 1", bus.cpu_req_ready); end
    m0 = mem_acc_cnt;
    start_req(1'b0, 32'h0000_3008, 32'd0, 4'd0, acc, ok1);
    wait_resp(rcyc, rd, ok2);
    vectors++; if ({ok1, ok2, rd} !== {2'b11, 32'hA000_0002}) begin miscompares++; $display("FAIL rstmid_new_rdata got %b/%h exp 11/a0000002", {ok1, ok2}, rd); end
    vectors++; if (rcyc - acc + 1 !== 6) begin miscompares++; $display("FAIL rstmid_new_latency got %0d exp 6", rcyc - acc + 1); end
    vectors++; if ({mem_acc_cnt - m0, last_addr} !== {32'd1, 32'h0000_3000}) begin
      miscompares++; $display("FAIL rstmid_new_memreq got %0d/%h exp 1/00003000", mem_acc_cnt - m0, last_addr); end
  endtask

  task automatic test_exclusive_strobes();
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL strobe_exclusive got %0d exp 0", both_cnt); end
  endtask

  initial begin
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_write = 1'b0;
    bus.cpu_req_addr  = 32'd0;
    bus.cpu_req_wdata = 32'd0;
    bus.cpu_req_wstrb = 4'd0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_store_hit();
    test_store_miss();
    test_ready_stall();
    test_reset_mid();
    test_exclusive_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM in front of the set-associative line cache. Accepts single-word CPU load/store requests and drives the cache's address, fill-write and CPU-write strobes.
- Read misses are refilled from the line-wide memory port.
- Stores are write-through, no-write-allocate: the cached line is merged on a hit, and the word is always forwarded to memory.
- Sits between the core's load/store unit and the memory/bus adapter.

Parameters:
- XLEN, 32, address and data word width.
- LINE_SIZE, 64, cache line size in bytes; must match the cache instance.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req_valid  in  1  CPU request valid.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_req_write  in  1  1 = store, 0 = load.
- cpu_req_addr  in  XLEN  byte address.
- cpu_req_wdata  in  XLEN  store data.
- cpu_req_wstrb  in  XLEN/8  store byte enables.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_rdata  out  XLEN  load data; 0 for stores.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  1 = word write, 0 = line read.
- mem_req_addr  out  XLEN  line-aligned for reads, word address for writes.
- mem_req_wdata  out  XLEN  write-through data.
- mem_req_wstrb  out  XLEN/8  write-through byte enables.
- mem_resp_valid  in  1  read line delivered / write acknowledged.
- mem_resp_line  in  8*LINE_SIZE  refill data.
- cache_address  out  XLEN  address to the cache.
- cache_mem_write_en  out  1  fill strobe to the cache.
- cache_cpu_write_en  out  1  store-merge strobe to the cache.
- cache_data_in  out  8*LINE_SIZE  line to write.
- cache_data_out  in  8*LINE_SIZE  line read from the cache.
- cache_hit  in  1  cache hit indication.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is asynchronous and active-high. It forces state IDLE and clears every output and every internal register to 0.
  - Reset mid-operation abandons the transaction; no response is produced. The memory side shares the same reset.
- Arithmetic and widths:
  - WOFF = log2(XLEN/8).
  - Word index = addr[log2(LINE_SIZE)-1 : WOFF].
  - Line address = addr with the low log2(LINE_SIZE) bits zeroed.
- Request latch: a request is accepted on cpu_req_valid && cpu_req_ready. Addr, write, wdata and wstrb are latched into req_* registers. cache_address = req_addr in every non-IDLE state.
- IDLE:
  - cpu_req_ready = 1; all other strobes 0.
  - On accept -> LOOKUP.
- LOOKUP:
  - Lasts one cycle; cache_hit and cache_data_out are sampled at its closing edge.
  - Read hit -> RESP; rdata = selected word of cache_data_out.
  - Read miss -> FILL_REQ.
  - Write hit -> MERGE; the merged line (bytes replaced per wstrb) is registered into the line buffer.
  - Write miss -> WT_REQ.
- MERGE:
  - cache_cpu_write_en = 1 for exactly one cycle; cache_data_in = line buffer.
  - -> WT_REQ.
- FILL_REQ:
  - mem_req_valid = 1, mem_req_write = 0, mem_req_addr = line address.
  - Signals held stable until mem_req_ready; then -> FILL_WAIT.
- FILL_WAIT:
  - On mem_resp_valid, mem_resp_line is latched into the line buffer -> FILL_WRITE.
- FILL_WRITE:
  - cache_mem_write_en = 1 for exactly one cycle; cache_data_in = line buffer.
  - rdata = selected word of the line buffer -> RESP. No re-lookup.
- WT_REQ:
  - mem_req_valid = 1, mem_req_write = 1.
  - mem_req_addr = req_addr with the low WOFF bits zeroed; wdata and wstrb from the latch.
  - On mem_req_ready -> WT_WAIT.
- WT_WAIT: on mem_resp_valid -> RESP.
- RESP:
  - cpu_resp_valid = 1 for one cycle; cpu_resp_rdata is registered and held until the next RESP.
  - -> IDLE. The next request is accepted no earlier than the cycle after RESP.
- Ordering and stray inputs:
  - cache_mem_write_en and cache_cpu_write_en are never asserted together.
  - Only one memory transaction is outstanding at a time.
  - mem_resp_valid outside FILL_WAIT/WT_WAIT is ignored.
- Latencies with memory ready/response immediate:
  - Read hit: 3 cycles from accept to resp.
  - Read miss: 6 cycles.
  - Write hit: 6 cycles.
  - Write miss: 5 cycles.

Optional Feature:
- Macro: CACHE_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_hits, stat_misses, stat_writes (32 bits each).
  - Counters increment at the LOOKUP closing edge: hit counts reads and writes; miss counts reads and writes; writes counts stores.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cache_ctrl_pkg holds the state enum (IDLE, LOOKUP, MERGE, FILL_REQ, FILL_WAIT, FILL_WRITE, WT_REQ, WT_WAIT, RESP) and the WOFF/offset width constants.
- One sub-module, line_word_merge: combinational word select and byte-strobe merge on a line. It is used by LOOKUP, MERGE and FILL_WRITE.

Test Plan:
- Read miss, addr 0x0000_1044, memory returns a line with word k = 0xA000_0000+k:
  - One read to 0x0000_1040.
  - cache_mem_write_en pulses for 1 cycle.
  - resp rdata 0xA000_0001.
- Repeat read of 0x0000_1048 after the fill:
  - No mem_req_valid.
  - resp rdata 0xA000_0002, 3 cycles after accept.
- Store hit, 0x0000_1044, wdata 0x1122_3344, wstrb 4'b0011:
  - cache_cpu_write_en pulses for 1 cycle; line word 1 = 0xA000_3344.
  - Memory write to 0x0000_1044 with wstrb 0011.
  - resp rdata 0.
- Store miss, 0x0000_8000:
  - No cache strobes.
  - One memory write.
  - resp after mem_resp_valid.
- mem_req_ready held low 5 cycles in FILL_REQ:
  - mem_req_addr and mem_req_valid stay stable; cpu_req_ready stays 0.
- reset asserted during FILL_WAIT:
  - All outputs 0 immediately.
  - A later mem_resp_valid is ignored; a new request completes normally.
